riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
- Instruction-fetch stage that feeds the decode stage (IF/ID boundary) of the pipelined RISC-V core.
- Owns the fetch PC and issues word reads to a fixed-latency instruction memory.
- Buffers returned words in a small prefetch queue and presents them in order, with PC, to decode under a valid/ready handshake.
- Handles decode stalls (ready low) and control-flow redirects (branch/jump), discarding wrong-path words.

Parameters:
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request this cycle.
- imem_addr  output  32  byte address of request; bits [1:0] always 0.
- imem_rvalid  input  1  read data valid; exactly one cycle after an accepted imem_req.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  queue head holds a valid instruction.
- if_instr  output  32  head instruction; 32'h0000_0013 (NOP) when if_valid=0.
- if_pc  output  32  PC of head instruction.
- id_ready  input  1  decode accepts head this cycle (low = stall).
- redirect_valid  input  1  redirect fetch this cycle.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (treated as 0).

Behaviour:
- Memory is always ready: a request with imem_req=1 is accepted that cycle; the response arrives on imem_rvalid the next cycle. At most one request is in flight (inflight flag).
- Reset (any cycle, including mid-operation): fetch_pc=RESET_PC, queue emptied, inflight=0, imem_req=0, if_valid=0, if_instr=NOP, if_pc=0. While reset is high, imem_rvalid is ignored.
- Issue rule: imem_req=1 iff !reset && !redirect_valid && (count + inflight) < DEPTH, using registered count. imem_addr=fetch_pc. On issue, fetch_pc += 4 (32-bit wrap: 32'hFFFF_FFFC → 0) and inflight is set.
- Response: if imem_rvalid && inflight && !kill, push {imem_rdata, pc_of_request} into the queue. Any imem_rvalid without a matching inflight request is dropped.
- Pop: if_valid && id_ready, unless redirect_valid is high that cycle.
- Steady-state throughput is 1 instruction/cycle with id_ready held high. Queue never overflows because issue reserves the slot.
- Simultaneous push and pop at count=DEPTH-1 or DEPTH: both occur and count is unchanged.
- Empty queue: if_valid=0, if_instr=NOP, and id_ready is ignored.
- Redirect in cycle t:
  - queue flushed (count=0 at t+1);
  - fetch_pc=redirect_pc & ~3;
  - imem_req=0 at t;
  - any response arriving at t+1 is killed;
  - a pending pop at t is cancelled.
  - First request at t+1; first if_valid at t+3.
  - Back-to-back redirects: the last one wins.
- Redirect while reset is high: ignored.
- Startup latency: reset falls before cycle 0; request at cycle 0, response at cycle 1, if_valid at cycle 2 with if_pc=RESET_PC.
- Queue implementation: registered head; if_* come straight from flops (no combinational path from imem_rdata to if_*). Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.

Decomposition:
- Shared package riscv_pkg: XLEN=32, NOP=32'h0000_0013, opcode constants (LW, SW, BEQ, ALUop), instruction field index constants.
- One sub-module: fetch_fifo, a synchronous FIFO of {pc, instr} with a synchronous flush input, push/pop, count, full/empty.

Test Plan:
- Reset release, id_ready=1 → addresses 0,4,8,… issued every cycle; if_valid at cycle 2 with if_pc=0, then consecutive PCs, 1 instr/cycle.
- Hold id_ready=0 from cycle 3 → count saturates at 4, imem_req drops, nothing lost; raise id_ready → if_pc continues 4,8,12,16… without gaps or duplicates.
- redirect_valid with redirect_pc=32'h0000_0103 while queue is full and a request is in flight → next request addr=32'h100, stale response dropped, first if_pc=32'h100 exactly 3 cycles after redirect.
- Redirect in two consecutive cycles (0x200, then 0x300) → only 0x300 stream appears; no 0x200 instruction is ever valid.
- Assert reset mid-stream for 1 cycle while imem_rvalid pulses → if_valid=0, if_instr=NOP, queue empty; restart fetch from RESET_PC.
- redirect_pc=32'hFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 in order.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, NOP encoding, opcodes, field positions
// and the fetch-queue entry payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LW  = 7'b000_0011;
  localparam logic [6:0] OPC_SW  = 7'b010_0011;
  localparam logic [6:0] OPC_BEQ = 7'b110_0011;
  localparam logic [6:0] OPC_ALU = 7'b011_0011;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned F3_MSB  = 14;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = 24;
  localparam int unsigned F7_LSB  = 25;
  localparam int unsigned F7_MSB  = 31;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Instruction-memory and IF/ID boundary signals of the fetch unit.
// master = fetch unit, slave = memory/decode side.
interface riscv_fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/riscv_fetch_unit_fifo.sv
// Prefetch queue of {pc, instr} with a registered head so decode sees flop outputs only.
// Flush and reset both empty the queue in one cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count,
  output logic             empty_c,
  output logic             full_c
);

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: XLEN'(0), instr: NOP};

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CNT_W-1:0] count_n;
  logic             do_push, do_pop;
  fetch_entry_t     head_n;

  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(DEPTH));

  // Next head: bypass the incoming word when it lands exactly at the new read slot
  always_comb begin
    do_pop   = pop && !empty_c;
    do_push  = push && (!full_c || do_pop);
    rd_ptr_n = rd_ptr + PTR_W'(do_pop);
    wr_ptr_n = wr_ptr + PTR_W'(do_push);
    count_n  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    head_n   = EMPTY_ENTRY;
    if (count_n != '0) begin
      head_n = (do_push && (rd_ptr_n == wr_ptr)) ? wdata : mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head       <= EMPTY_ENTRY;
      head_valid <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count      <= count_n;
      head       <= head_n;
      head_valid <= (count_n != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word read at a time to a
// one-cycle-latency memory and queues returned words for decode.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  riscv_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  inflight_pc;
  logic             inflight;
  logic             kill;
  logic             slots_free_c, issue_c, push_c, pop_c;
  logic [CNT_W-1:0] count;
  logic             empty_c, full_c, head_valid;
  fetch_entry_t     head, push_entry;

  // An in-flight request already owns a queue slot
  assign slots_free_c = !full_c && !(inflight && (count == CNT_W'(DEPTH - 1)));
  assign issue_c      = !reset && !bus.redirect_valid && slots_free_c;
  assign push_c       = bus.imem_rvalid && inflight && !kill && !reset;
  assign pop_c        = !empty_c && bus.id_ready && !bus.redirect_valid;
  assign push_entry   = '{pc: inflight_pc, instr: bus.imem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      kill     <= bus.redirect_valid;
      inflight <= issue_c;
      if (issue_c) begin
        inflight_pc <= fetch_pc;
      end
      if (bus.redirect_valid) begin
        fetch_pc <= align_word(bus.redirect_pc);
      end else if (issue_c) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.redirect_valid),
    .push       (push_c),
    .pop        (pop_c),
    .wdata      (push_entry),
    .head       (head),
    .head_valid (head_valid),
    .count      (count),
    .empty_c    (empty_c),
    .full_c     (full_c)
  );

  assign bus.imem_req  = issue_c;
  assign bus.imem_addr = fetch_pc;
  assign bus.if_valid  = head_valid;
  assign bus.if_instr  = head.instr;
  assign bus.if_pc     = head.pc;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: per-cycle vector table plus hand-written
// wrap-around and stall/drain sequences against a one-cycle-latency memory.
module tb_riscv_fetch_unit;
  import riscv_pkg::*;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = '0;
  logic        inject     = 1'b0;
  int unsigned checks     = 0;
  int unsigned passes     = 0;

  riscv_fetch_unit_if bus ();

  riscv_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hAB00_0000 ^ a;
  endfunction

  // Memory: answers every request one cycle later; inject adds spurious rvalid pulses
  always @(posedge clk) begin
    mem_rvalid <= bus.imem_req;
    mem_rdata  <= instr_of(bus.imem_addr);
  end
  assign bus.imem_rvalid = mem_rvalid | inject;
  assign bus.imem_rdata  = mem_rdata;

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rpc;
    logic        inj;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, input logic rdy, input logic rv,
                             input logic [31:0] rpc, input logic inj, input logic e_req,
                             input logic [31:0] e_addr, input logic e_val,
                             input logic [31:0] e_pc);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.inj = inj;
    r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val; r.e_pc = e_pc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Drive one cycle of inputs just after the edge, return mid-cycle for sampling
  task automatic cyc(input logic rst, input logic rdy, input logic rv,
                     input logic [31:0] rpc, input logic inj);
    @(posedge clk);
    #1;
    reset              = rst;
    bus.id_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    inject             = inj;
    #3;
  endtask

  task automatic check_head(input string name, input logic e_val, input logic [31:0] e_pc);
    check({name, " valid"}, 32'(bus.if_valid), 32'(e_val));
    check({name, " pc"}, bus.if_pc, e_pc);
    check({name, " instr"}, bus.if_instr, e_val ? instr_of(e_pc) : NOP);
  endtask

  initial begin
    int unsigned got;
    int unsigned used;
    logic [31:0] exp_pc;

    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);

    //                rst rdy rv rpc           inj req addr          val pc
    vecs.push_back(v(1, 1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h4,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h8,         1, 32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,         0, 1, 32'hC,         1, 32'h4));
    vecs.push_back(v(0, 0, 0, 32'h0,         0, 1, 32'h10,        1, 32'h4));
    vecs.push_back(v(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4));
    vecs.push_back(v(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h14,        1, 32'h8));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h18,        1, 32'hC));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h1C,        1, 32'h10));
    vecs.push_back(v(0, 0, 0, 32'h0,         0, 1, 32'h20,        1, 32'h14));
    vecs.push_back(v(0, 1, 1, 32'h103,       0, 0, 32'h0,         1, 32'h14));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h100,       0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h104,       0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h108,       1, 32'h100));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h10C,       1, 32'h104));
    vecs.push_back(v(0, 1, 1, 32'h200,       0, 0, 32'h0,         1, 32'h108));
    vecs.push_back(v(0, 1, 1, 32'h300,       0, 0, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h300,       0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h304,       0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h308,       1, 32'h300));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h30C,       1, 32'h304));
    vecs.push_back(v(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h308));
    vecs.push_back(v(0, 1, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h4,         0, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'h8,         1, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,         0, 1, 32'hC,         1, 32'h4));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].inj);
      check($sformatf("v%0d req", i), 32'(bus.imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) check($sformatf("v%0d addr", i), bus.imem_addr, vecs[i].e_addr);
      check_head($sformatf("v%0d", i), vecs[i].e_val, vecs[i].e_pc);
    end

    // Address wrap at the top of the 32-bit space
    cyc(0, 1, 1, 32'hFFFF_FFF8, 0);
    check("wrap req@t", 32'(bus.imem_req), 32'h0);
    cyc(0, 1, 0, 32'h0, 0);
    check("wrap addr0", bus.imem_addr, 32'hFFFF_FFF8);
    cyc(0, 1, 0, 32'h0, 0);
    check("wrap addr1", bus.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 32'h0, 0);
    check("wrap addr2", bus.imem_addr, 32'h0000_0000);
    check_head("wrap h0", 1'b1, 32'hFFFF_FFF8);
    cyc(0, 1, 0, 32'h0, 0);
    check_head("wrap h1", 1'b1, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 32'h0, 0);
    check_head("wrap h2", 1'b1, 32'h0000_0000);

    // Stall until the queue saturates, then drain without gaps or duplicates
    cyc(0, 0, 1, 32'h400, 0);
    repeat (8) cyc(0, 0, 0, 32'h0, 0);
    check("stall req", 32'(bus.imem_req), 32'h0);
    check_head("stall head", 1'b1, 32'h400);
    got    = 0;
    used   = 0;
    exp_pc = 32'h400;
    for (int k = 0; k < 40 && got < 8; k++) begin
      cyc(0, 1, 0, 32'h0, 0);
      used++;
      if (bus.if_valid) begin
        check($sformatf("drain pc%0d", got), bus.if_pc, exp_pc);
        check($sformatf("drain instr%0d", got), bus.if_instr, instr_of(exp_pc));
        exp_pc += 32'h4;
        got++;
      end
    end
    if (got < 8) begin
      checks++;
      $display("FAIL drain timeout: got %0d instructions expected 8", got);
    end else begin
      check("drain cycles", 32'(used), 32'd8);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
